sd_cmd_arbiter: RTL
===================

Name: sd_cmd_arbiter

Overview:
- Shares the single SDIO CMD controller between the sector reader (requester R) and the sector writer (requester W).
- Each requester keeps its native set_cmd-style interface: a start pulse carrying precnt/cmd/arg, and receives busy/done/timeout/syntaxe/resparg.
- The arbiter captures each request, grants the controller to one requester at a time (round-robin), issues the command, and routes the response only to the owner.

Parameters:
- RESET_CLKDIV, 16'd96, clkdiv driven to the controller from reset until the first grant.
- WDOG_CYCLES, 32'd2000000, clk cycles allowed between issued start and controller done before the watchdog forces release (used only with SD_ARB_WDOG_EN).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- r_clkdiv, w_clkdiv  in  16  requester SD clock divider
- r_start, w_start  in  1  one-cycle command request pulse
- r_precnt, w_precnt  in  16  pre-command idle count
- r_cmd, w_cmd  in  6  command index
- r_arg, w_arg  in  32  command argument
- r_busy, w_busy  out  1  requester must not pulse start while high
- r_done, w_done  out  1  one-cycle completion pulse
- r_timeout, w_timeout, r_syntaxe, w_syntaxe  out  1  response status, valid with done
- r_resparg, w_resparg  out  32  response argument, valid with done
- clkdiv  out  16  to controller
- start  out  1  to controller, one-cycle pulse
- precnt  out  16  to controller
- cmd  out  6  to controller
- arg  out  32  to controller
- busy, done, timeout, syntaxe  in  1  from controller
- resparg  in  32  from controller

Behaviour:
- Reset values: start=0, precnt=0, cmd=0, arg=0, clkdiv=RESET_CLKDIV. All pending flags clear. State IDLE. last_grant=W, so R wins the first tie. All requester outputs are 0.
- Capture: x_start=1 while pending_x=0 latches {precnt,cmd,arg,clkdiv}_x and sets pending_x on the next edge. x_start while pending_x=1 is ignored; the first request is kept.
- x_busy is registered and equals pending_x. It is high from the cycle after x_start until the cycle after x_done.
- IDLE:
  - If any request is pending, grant it.
  - If both are pending (including simultaneous starts), grant the one that is not last_grant.
  - Set owner and last_grant, then go to ISSUE.
- ISSUE:
  - Drive clkdiv from the owner's latched value; clkdiv holds that value after release.
  - When controller busy=0, pulse start=1 for exactly one cycle with the owner's latched precnt/cmd/arg, then go to WAIT.
  - If busy=1, stay in ISSUE.
- WAIT:
  - When controller done=1: owner's done_x=1 that cycle (combinational pass-through), timeout_x/syntaxe_x/resparg_x muxed from the controller.
  - Clear pending_x at the next edge, return to IDLE.
- Non-owner outputs: done/timeout/syntaxe = 0, resparg = 0.
- Controller done outside WAIT is ignored.
- Latency: earliest controller start is 2 cycles after x_start (capture, grant). Back-to-back service alternates R/W when both requesters stay loaded.
- Reset mid-operation: everything returns to reset values immediately. An in-flight controller command completes unobserved; the next ISSUE waits for busy=0.

Optional Feature:
- Macro SD_ARB_WDOG_EN.
- Defined: a 32-bit counter starts at the start pulse. If WDOG_CYCLES elapse in WAIT without done:
  - pulse done_x=1 with timeout_x=1, syntaxe_x=0, resparg_x=0;
  - clear pending_x and go to IDLE;
  - a later stray controller done is ignored.
- Undefined: no counter; WAIT holds until done.

Decomposition:
- Package sd_arb_pkg:
  - state encoding IDLE/ISSUE/WAIT (2-bit);
  - requester IDs REQ_R=0, REQ_W=1;
  - width constants for precnt/cmd/arg/clkdiv.
- Sub-module sd_cmd_req_latch, instantiated once per requester: start capture, pending flag, busy output, clear input.

Test Plan:
- R pulses start (cmd=8, arg=0x1AA, precnt=512) -> controller start pulse 2 cycles later with cmd=8/arg=0x1AA/precnt=512. Controller done with resparg=0x1AA -> r_done for 1 cycle with r_resparg=0x1AA, w_done stays 0, r_busy falls the next cycle.
- R and W pulse start in the same cycle (cmd 17 and cmd 24) -> cmd 17 issued first, cmd 24 only after R's done. Second simultaneous pair -> R and W alternate per last_grant.
- Controller busy held high for 20 cycles when W requests -> start withheld until busy=0, then exactly one pulse.
- R pulses start twice while pending (arg 0x10, then 0x20) -> only arg=0x10 issued, single r_done.
- rstn asserted in WAIT -> start=0, clkdiv=96, both busy=0, state IDLE. A later controller done produces no requester done.
- SD_ARB_WDOG_EN, WDOG_CYCLES=100, controller never completes -> w_done and w_timeout=1 at cycle 100 after start. A subsequent R request is served normally.

Source files
------------

// File: rtl/sd_arb_pkg.sv
// ------------------------------------------------------------------
// sd_arb_pkg : shared types and widths for the SD CMD arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_R = 1'b0;
    localparam logic REQ_W = 1'b1;

    localparam int PRECNT_W = 16;
    localparam int CMD_W    = 6;
    localparam int ARG_W    = 32;
    localparam int CLKDIV_W = 16;

endpackage

`default_nettype wire

// File: rtl/sd_cmd_req_latch.sv
// ------------------------------------------------------------------
// sd_cmd_req_latch : captures one requester's command and holds it
//                    pending until the arbiter clears it.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sd_cmd_req_latch
    import sd_arb_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                i_start,
    input  logic [PRECNT_W-1:0] i_precnt,
    input  logic [CMD_W-1:0]    i_cmd,
    input  logic [ARG_W-1:0]    i_arg,
    input  logic [CLKDIV_W-1:0] i_clkdiv,
    input  logic                i_clr,
    output logic                o_pending,
    output logic [PRECNT_W-1:0] o_precnt,
    output logic [CMD_W-1:0]    o_cmd,
    output logic [ARG_W-1:0]    o_arg,
    output logic [CLKDIV_W-1:0] o_clkdiv
);

    logic                r_pending;
    logic [PRECNT_W-1:0] r_precnt;
    logic [CMD_W-1:0]    r_cmd;
    logic [ARG_W-1:0]    r_arg;
    logic [CLKDIV_W-1:0] r_clkdiv;

    // A start while already pending is dropped so the first request survives.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= 1'b0;
            r_precnt  <= '0;
            r_cmd     <= '0;
            r_arg     <= '0;
            r_clkdiv  <= '0;
        end else if (i_clr) begin
            r_pending <= 1'b0;
        end else if (i_start && !r_pending) begin
            r_pending <= 1'b1;
            r_precnt  <= i_precnt;
            r_cmd     <= i_cmd;
            r_arg     <= i_arg;
            r_clkdiv  <= i_clkdiv;
        end
    end

    assign o_pending = r_pending;
    assign o_precnt  = r_precnt;
    assign o_cmd     = r_cmd;
    assign o_arg     = r_arg;
    assign o_clkdiv  = r_clkdiv;

endmodule

`default_nettype wire

// File: rtl/sd_cmd_arbiter.sv
// ------------------------------------------------------------------
// sd_cmd_arbiter : round-robin share of one SDIO CMD controller between
//                  sector reader (R) and writer (W). Option: SD_ARB_WDOG_EN.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sd_cmd_arbiter
    import sd_arb_pkg::*;
#(
    parameter logic [15:0] RESET_CLKDIV = 16'd96,
    parameter logic [31:0] WDOG_CYCLES  = 32'd2000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] r_clkdiv,
    input  logic [15:0] w_clkdiv,
    input  logic        r_start,
    input  logic        w_start,
    input  logic [15:0] r_precnt,
    input  logic [15:0] w_precnt,
    input  logic [5:0]  r_cmd,
    input  logic [5:0]  w_cmd,
    input  logic [31:0] r_arg,
    input  logic [31:0] w_arg,
    output logic        r_busy,
    output logic        w_busy,
    output logic        r_done,
    output logic        w_done,
    output logic        r_timeout,
    output logic        w_timeout,
    output logic        r_syntaxe,
    output logic        w_syntaxe,
    output logic [31:0] r_resparg,
    output logic [31:0] w_resparg,
    output logic [15:0] clkdiv,
    output logic        start,
    output logic [15:0] precnt,
    output logic [5:0]  cmd,
    output logic [31:0] arg,
    input  logic        busy,
    input  logic        done,
    input  logic        timeout,
    input  logic        syntaxe,
    input  logic [31:0] resparg
);

    logic                w_rq_pend, w_wq_pend;
    logic [PRECNT_W-1:0] w_rq_precnt, w_wq_precnt;
    logic [CMD_W-1:0]    w_rq_cmd, w_wq_cmd;
    logic [ARG_W-1:0]    w_rq_arg, w_wq_arg;
    logic [CLKDIV_W-1:0] w_rq_clkdiv, w_wq_clkdiv;

    arb_state_t          r_state;
    logic                r_owner;
    logic                r_last;
    logic [CLKDIV_W-1:0] r_clkdiv_q;
    logic [PRECNT_W-1:0] r_precnt_q;
    logic [CMD_W-1:0]    r_cmd_q;
    logic [ARG_W-1:0]    r_arg_q;

    logic w_pick, w_issue, w_wdog_fire, w_fin, w_fin_r, w_fin_w;
    logic w_tmo, w_syn;
    logic [31:0] w_rsp;

    sd_cmd_req_latch u_req_r (
        .clk       (clk),
        .rstn      (rstn),
        .i_start   (r_start),
        .i_precnt  (r_precnt),
        .i_cmd     (r_cmd),
        .i_arg     (r_arg),
        .i_clkdiv  (r_clkdiv),
        .i_clr     (w_fin_r),
        .o_pending (w_rq_pend),
        .o_precnt  (w_rq_precnt),
        .o_cmd     (w_rq_cmd),
        .o_arg     (w_rq_arg),
        .o_clkdiv  (w_rq_clkdiv)
    );

    sd_cmd_req_latch u_req_w (
        .clk       (clk),
        .rstn      (rstn),
        .i_start   (w_start),
        .i_precnt  (w_precnt),
        .i_cmd     (w_cmd),
        .i_arg     (w_arg),
        .i_clkdiv  (w_clkdiv),
        .i_clr     (w_fin_w),
        .o_pending (w_wq_pend),
        .o_precnt  (w_wq_precnt),
        .o_cmd     (w_wq_cmd),
        .o_arg     (w_wq_arg),
        .o_clkdiv  (w_wq_clkdiv)
    );

    // On a tie the requester that was not granted last wins.
    assign w_pick  = (w_rq_pend && w_wq_pend) ? ~r_last :
                     (w_rq_pend ? REQ_R : REQ_W);
    assign w_issue = (r_state == ST_ISSUE) && !busy;

`ifdef SD_ARB_WDOG_EN
    logic [31:0] r_wdog;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= '0;
        end else if (w_issue) begin
            r_wdog <= 32'd1;
        end else if (r_state == ST_WAIT) begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

    assign w_wdog_fire = (r_state == ST_WAIT) && !done && (r_wdog >= WDOG_CYCLES);
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^WDOG_CYCLES;
    assign w_wdog_fire   = 1'b0;
`endif

    assign w_fin   = (r_state == ST_WAIT) && (done || w_wdog_fire);
    assign w_fin_r = w_fin && (r_owner == REQ_R);
    assign w_fin_w = w_fin && (r_owner == REQ_W);
    assign w_tmo   = w_wdog_fire ? 1'b1 : timeout;
    assign w_syn   = w_wdog_fire ? 1'b0 : syntaxe;
    assign w_rsp   = w_wdog_fire ? 32'd0 : resparg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_owner    <= REQ_R;
            r_last     <= REQ_W;
            r_clkdiv_q <= RESET_CLKDIV;
            r_precnt_q <= '0;
            r_cmd_q    <= '0;
            r_arg_q    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rq_pend || w_wq_pend) begin
                        r_owner    <= w_pick;
                        r_last     <= w_pick;
                        r_clkdiv_q <= (w_pick == REQ_W) ? w_wq_clkdiv : w_rq_clkdiv;
                        r_precnt_q <= (w_pick == REQ_W) ? w_wq_precnt : w_rq_precnt;
                        r_cmd_q    <= (w_pick == REQ_W) ? w_wq_cmd    : w_rq_cmd;
                        r_arg_q    <= (w_pick == REQ_W) ? w_wq_arg    : w_rq_arg;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!busy) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_fin) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign start  = w_issue;
    assign clkdiv = r_clkdiv_q;
    assign precnt = r_precnt_q;
    assign cmd    = r_cmd_q;
    assign arg    = r_arg_q;

    assign r_busy    = w_rq_pend;
    assign w_busy    = w_wq_pend;
    assign r_done    = w_fin_r;
    assign w_done    = w_fin_w;
    assign r_timeout = w_fin_r & w_tmo;
    assign w_timeout = w_fin_w & w_tmo;
    assign r_syntaxe = w_fin_r & w_syn;
    assign w_syntaxe = w_fin_w & w_syn;
    assign r_resparg = w_fin_r ? w_rsp : 32'd0;
    assign w_resparg = w_fin_w ? w_rsp : 32'd0;

endmodule

`default_nettype wire
